// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: 3-entry EX/MA/WB write scoreboard with RAW stall, branch flush and halt/drain/resume.
// Outputs are combinational from registered state; no forwarding, so a reader waits until its writer leaves WB.
module pipe_ctrl #(
  parameter int GP_W      = 4,
  parameter int SR_W      = 2,
  parameter int FLUSH_CYC = 2
) (
  input  logic            iw_clk,
  input  logic            iw_rst,
  input  logic            iw_id_valid,
  input  logic [GP_W-1:0] iw_id_src_gp,
  input  logic            iw_id_src_gp_re,
  input  logic [GP_W-1:0] iw_id_tgt_gp,
  input  logic            iw_id_tgt_gp_re,
  input  logic            iw_id_tgt_gp_we,
  input  logic [SR_W-1:0] iw_id_src_sr,
  input  logic            iw_id_src_sr_re,
  input  logic [SR_W-1:0] iw_id_tgt_sr,
  input  logic            iw_id_tgt_sr_we,
  input  logic            iw_ex_branch_taken,
  input  logic            iw_halt_req,
  input  logic            iw_resume,
  output logic            ow_stall,
  output logic            ow_bubble_ex,
  output logic            ow_flush,
  output logic            ow_halted,
  output logic            ow_busy
);

  localparam int CNT_W = 3;

  typedef struct packed {
    logic            gp_v;
    logic [GP_W-1:0] gp_idx;
    logic            sr_v;
    logic [SR_W-1:0] sr_idx;
  } sb_ent_t;

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DRAIN, ST_HALT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sb_ent_t          sb_q [3];  // 0 = EX, 1 = MA, 2 = WB
  sb_ent_t          sb_ex_d;
  logic             hazard;
  logic             issue;
  logic             busy;

  // An entry leaving WB still blocks: the register file writes at the end of that cycle.
  always_comb begin
    hazard = 1'b0;
    busy   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (sb_q[i].gp_v &&
          ((iw_id_src_gp_re && (sb_q[i].gp_idx == iw_id_src_gp)) ||
           (iw_id_tgt_gp_re && (sb_q[i].gp_idx == iw_id_tgt_gp))))
        hazard = 1'b1;
      if (sb_q[i].sr_v && iw_id_src_sr_re && (sb_q[i].sr_idx == iw_id_src_sr))
        hazard = 1'b1;
      if (sb_q[i].gp_v || sb_q[i].sr_v)
        busy = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    issue    = 1'b0;
    ow_stall = 1'b0;
    ow_flush = 1'b0;
    case (state_q)
      ST_RUN: begin
        issue    = iw_id_valid & ~hazard & ~iw_ex_branch_taken;
        ow_stall = iw_id_valid & hazard & ~iw_ex_branch_taken;
        ow_flush = iw_ex_branch_taken;
        if (iw_ex_branch_taken) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYC - 1);
        end else if (iw_halt_req) begin
          state_d = ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0)
          state_d = iw_halt_req ? ST_DRAIN : ST_RUN;
        else
          cnt_d = cnt_q - CNT_W'(1);
      end
      ST_DRAIN: begin
        ow_stall = 1'b1;
        if (!busy)
          state_d = ST_HALT;
      end
      ST_HALT: begin
        ow_stall = 1'b1;
        if (iw_resume)
          state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    sb_ex_d = '0;
    if (issue) begin
      sb_ex_d.gp_v   = iw_id_tgt_gp_we;
      sb_ex_d.gp_idx = iw_id_tgt_gp;
      sb_ex_d.sr_v   = iw_id_tgt_sr_we;
      sb_ex_d.sr_idx = iw_id_tgt_sr;
    end
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      for (int i = 0; i < 3; i++)
        sb_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sb_q[2] <= sb_q[1];
      sb_q[1] <= sb_q[0];
      sb_q[0] <= sb_ex_d;
    end
  end

  assign ow_bubble_ex = ~issue;
  assign ow_halted    = (state_q == ST_HALT);
  assign ow_busy      = busy;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: table vectors, hand sequences for drain/halt/flush/reset, then random stimulus vs a cycle-count model.
module tb_pipe_ctrl;
  localparam int GP_W = 4;
  localparam int SR_W = 2;
  localparam int FLUSH_CYC = 2;

  logic            iw_clk = 1'b0;
  logic            iw_rst;
  logic            iw_id_valid;
  logic [GP_W-1:0] iw_id_src_gp;
  logic            iw_id_src_gp_re;
  logic [GP_W-1:0] iw_id_tgt_gp;
  logic            iw_id_tgt_gp_re;
  logic            iw_id_tgt_gp_we;
  logic [SR_W-1:0] iw_id_src_sr;
  logic            iw_id_src_sr_re;
  logic [SR_W-1:0] iw_id_tgt_sr;
  logic            iw_id_tgt_sr_we;
  logic            iw_ex_branch_taken;
  logic            iw_halt_req;
  logic            iw_resume;
  logic            ow_stall, ow_bubble_ex, ow_flush, ow_halted, ow_busy;

  pipe_ctrl #(.GP_W(GP_W), .SR_W(SR_W), .FLUSH_CYC(FLUSH_CYC)) dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_id_valid(iw_id_valid),
    .iw_id_src_gp(iw_id_src_gp), .iw_id_src_gp_re(iw_id_src_gp_re),
    .iw_id_tgt_gp(iw_id_tgt_gp), .iw_id_tgt_gp_re(iw_id_tgt_gp_re),
    .iw_id_tgt_gp_we(iw_id_tgt_gp_we), .iw_id_src_sr(iw_id_src_sr),
    .iw_id_src_sr_re(iw_id_src_sr_re), .iw_id_tgt_sr(iw_id_tgt_sr),
    .iw_id_tgt_sr_we(iw_id_tgt_sr_we), .iw_ex_branch_taken(iw_ex_branch_taken),
    .iw_halt_req(iw_halt_req), .iw_resume(iw_resume),
    .ow_stall(ow_stall), .ow_bubble_ex(ow_bubble_ex), .ow_flush(ow_flush),
    .ow_halted(ow_halted), .ow_busy(ow_busy)
  );

  always #5 iw_clk = ~iw_clk;

  typedef struct packed {
    logic       valid;
    logic [3:0] src_gp;
    logic       src_gp_re;
    logic [3:0] tgt_gp;
    logic       tgt_gp_re;
    logic       tgt_gp_we;
    logic [1:0] src_sr;
    logic       src_sr_re;
    logic [1:0] tgt_sr;
    logic       tgt_sr_we;
    logic       br;
    logic       halt;
    logic       resume;
  } in_t;

  // expected bits: {stall, bubble_ex, flush, halted, busy}
  typedef struct {
    in_t        i;
    logic [4:0] e;
    string      nm;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: a register is unreadable for the 3 cycles after its writer issues.
  localparam int M_RUN = 0, M_FLUSH = 1, M_DRAIN = 2, M_HALT = 3;
  int now;
  int gp_rdy [16];
  int sr_rdy [4];
  int last_w;
  int mode;
  int flush_left;

  function automatic void model_reset();
    now = 0;
    for (int k = 0; k < 16; k++) gp_rdy[k] = 0;
    for (int k = 0; k < 4; k++) sr_rdy[k] = 0;
    last_w = -100;
    mode = M_RUN;
    flush_left = 0;
  endfunction

  function automatic logic model_hz(in_t v);
    return (v.src_gp_re && (now < gp_rdy[v.src_gp])) ||
           (v.tgt_gp_re && (now < gp_rdy[v.tgt_gp])) ||
           (v.src_sr_re && (now < sr_rdy[v.src_sr]));
  endfunction

  function automatic logic model_issue(in_t v);
    return (mode == M_RUN) && v.valid && !model_hz(v) && !v.br;
  endfunction

  function automatic logic [4:0] model_out(in_t v);
    logic run;
    run = (mode == M_RUN);
    return {(run && v.valid && model_hz(v) && !v.br) || (mode == M_DRAIN) || (mode == M_HALT),
            !model_issue(v), run && v.br, mode == M_HALT, now < last_w + 4};
  endfunction

  function automatic void model_update(in_t v);
    logic busy;
    busy = (now < last_w + 4);
    if (model_issue(v)) begin
      if (v.tgt_gp_we) gp_rdy[v.tgt_gp] = now + 4;
      if (v.tgt_sr_we) sr_rdy[v.tgt_sr] = now + 4;
      if (v.tgt_gp_we || v.tgt_sr_we) last_w = now;
    end
    case (mode)
      M_RUN:   if (v.br) begin mode = M_FLUSH; flush_left = FLUSH_CYC; end
               else if (v.halt) mode = M_DRAIN;
      M_FLUSH: begin
        flush_left--;
        if (flush_left == 0) mode = v.halt ? M_DRAIN : M_RUN;
      end
      M_DRAIN: if (!busy) mode = M_HALT;
      default: if (v.resume) mode = M_RUN;
    endcase
    now++;
  endfunction

  function automatic in_t f_nop();
    in_t v;
    v = '0;
    return v;
  endfunction
  function automatic in_t f_wr(int r);
    in_t v;
    v = '0; v.valid = 1'b1; v.tgt_gp = 4'(r); v.tgt_gp_we = 1'b1;
    return v;
  endfunction
  function automatic in_t f_rd(int r);
    in_t v;
    v = '0; v.valid = 1'b1; v.src_gp = 4'(r); v.src_gp_re = 1'b1;
    return v;
  endfunction
  function automatic in_t f_rmw(int r);
    in_t v;
    v = f_wr(r); v.tgt_gp_re = 1'b1;
    return v;
  endfunction
  function automatic in_t f_wsr(int s);
    in_t v;
    v = '0; v.valid = 1'b1; v.tgt_sr = 2'(s); v.tgt_sr_we = 1'b1;
    return v;
  endfunction
  function automatic in_t f_rsr(int s);
    in_t v;
    v = '0; v.valid = 1'b1; v.src_sr = 2'(s); v.src_sr_re = 1'b1;
    return v;
  endfunction

  function automatic logic [4:0] dut_out();
    return {ow_stall, ow_bubble_ex, ow_flush, ow_halted, ow_busy};
  endfunction

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: {stall,bubble,flush,halted,busy} got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input in_t v);
    iw_id_valid        = v.valid;
    iw_id_src_gp       = v.src_gp;
    iw_id_src_gp_re    = v.src_gp_re;
    iw_id_tgt_gp       = v.tgt_gp;
    iw_id_tgt_gp_re    = v.tgt_gp_re;
    iw_id_tgt_gp_we    = v.tgt_gp_we;
    iw_id_src_sr       = v.src_sr;
    iw_id_src_sr_re    = v.src_sr_re;
    iw_id_tgt_sr       = v.tgt_sr;
    iw_id_tgt_sr_we    = v.tgt_sr_we;
    iw_ex_branch_taken = v.br;
    iw_halt_req        = v.halt;
    iw_resume          = v.resume;
  endtask

  task automatic step(input in_t v, input string nm, input logic [4:0] tab, input bit use_tab,
                      output logic [4:0] got);
    @(negedge iw_clk);
    apply(v);
    #1;
    got = dut_out();
    chk({nm, "/model"}, got, model_out(v));
    if (use_tab) chk({nm, "/table"}, got, tab);
    @(posedge iw_clk);
    model_update(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tab [$];
    in_t        v;
    logic [4:0] o;
    logic       got_halt;
    logic       halt_lvl;

    // RAW on GP via src, independent stream, branch flush, SR hazard, tgt-read hazard
    tab.push_back('{f_wr(3),  5'b00000, "raw_wr_r3"});
    tab.push_back('{f_rd(3),  5'b11001, "raw_stall_ex"});
    tab.push_back('{f_rd(3),  5'b11001, "raw_stall_ma"});
    tab.push_back('{f_rd(3),  5'b11001, "raw_stall_wb"});
    tab.push_back('{f_rd(3),  5'b00000, "raw_issue"});
    tab.push_back('{f_nop(),  5'b01000, "idle"});
    tab.push_back('{f_wr(1),  5'b00000, "ind_wr_r1"});
    tab.push_back('{f_wr(2),  5'b00001, "ind_wr_r2"});
    tab.push_back('{f_wr(4),  5'b00001, "ind_wr_r4"});
    tab.push_back('{f_rd(5),  5'b00001, "ind_rd_r5"});
    tab.push_back('{f_nop(),  5'b01001, "ind_tail1"});
    tab.push_back('{f_nop(),  5'b01001, "ind_tail2"});
    tab.push_back('{f_nop(),  5'b01000, "ind_empty"});
    tab.push_back('{f_wr(3),  5'b00000, "br_prewr_r3"});
    v = f_rd(3); v.tgt_gp = 4'd7; v.tgt_gp_we = 1'b1; v.br = 1'b1;
    tab.push_back('{v,        5'b01101, "br_cycle"});
    tab.push_back('{f_rd(7),  5'b01001, "br_flush1"});
    tab.push_back('{f_rd(7),  5'b01001, "br_flush2"});
    tab.push_back('{f_rd(7),  5'b00000, "br_after_no_rec"});
    tab.push_back('{f_wsr(2), 5'b00000, "sr_wr2"});
    tab.push_back('{f_rsr(2), 5'b11001, "sr_raw_stall"});
    tab.push_back('{f_rsr(1), 5'b00001, "sr_other_idx"});
    tab.push_back('{f_wr(8),  5'b00001, "tgt_wr_r8"});
    tab.push_back('{f_rmw(8), 5'b11001, "tgt_rd_stall1"});
    tab.push_back('{f_rmw(8), 5'b11001, "tgt_rd_stall2"});
    tab.push_back('{f_rmw(8), 5'b11001, "tgt_rd_stall3"});
    tab.push_back('{f_rmw(8), 5'b00000, "tgt_rd_issue"});
    tab.push_back('{f_nop(),  5'b01001, "tgt_tail"});

    apply(f_nop());
    iw_rst = 1'b1;
    model_reset();
    #1;
    chk("reset_state", dut_out(), 5'b01000);
    repeat (2) @(posedge iw_clk);
    @(negedge iw_clk);
    iw_rst = 1'b0;

    foreach (tab[k]) step(tab[k].i, tab[k].nm, tab[k].e, 1'b1, o);

    // Halt with two writes in flight
    step(f_wr(1), "halt_wr1", 5'b0, 1'b0, o);
    step(f_wr(2), "halt_wr2", 5'b0, 1'b0, o);
    v = f_nop(); v.halt = 1'b1;
    step(v, "halt_req", 5'b0, 1'b0, o);
    v = f_rd(1); v.halt = 1'b1;
    step(v, "drain_first", 5'b11001, 1'b1, o);
    got_halt = 1'b0;
    for (int k = 0; k < 4 && !got_halt; k++) begin
      step(v, "drain_wait", 5'b0, 1'b0, o);
      got_halt = o[1];
    end
    chk("halted_within_bound", {4'b0, got_halt}, 5'b00001);
    v = f_wr(5); v.resume = 1'b1;
    step(v, "resume_cycle", 5'b11010, 1'b1, o);
    step(f_wr(5), "resume_issue", 5'b00000, 1'b1, o);
    repeat (3) step(f_nop(), "settle", 5'b0, 1'b0, o);

    // Branch and halt together: flush first, then drain, then halt
    v = f_wr(6); v.br = 1'b1; v.halt = 1'b1;
    step(v, "brhalt_cycle", 5'b01100, 1'b1, o);
    v = f_nop(); v.halt = 1'b1;
    step(v, "brhalt_flush1", 5'b01000, 1'b1, o);
    step(v, "brhalt_flush2", 5'b01000, 1'b1, o);
    step(v, "brhalt_drain", 5'b11000, 1'b1, o);
    step(v, "brhalt_halt", 5'b11010, 1'b1, o);
    v = f_nop(); v.resume = 1'b1;
    step(v, "brhalt_resume", 5'b11010, 1'b1, o);
    step(f_nop(), "brhalt_run", 5'b01000, 1'b1, o);

    // Asynchronous reset in the middle of a RAW stall
    step(f_wr(3), "rst_wr_r3", 5'b00000, 1'b1, o);
    step(f_rd(3), "rst_stall1", 5'b11001, 1'b1, o);
    @(negedge iw_clk);
    apply(f_rd(3));
    #1;
    chk("rst_stall2/model", dut_out(), model_out(f_rd(3)));
    iw_rst = 1'b1;
    #1;
    model_reset();
    chk("rst_async_clear", dut_out(), 5'b00000);
    @(posedge iw_clk);
    #1;
    chk("rst_held", dut_out(), 5'b00000);
    @(negedge iw_clk);
    iw_rst = 1'b0;
    step(f_rd(3), "rst_first_issue", 5'b00000, 1'b1, o);

    // Random stimulus against the model
    halt_lvl = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      v = '0;
      v.valid     = ($urandom % 4) != 0;
      v.src_gp    = 4'($urandom_range(0, 3));
      v.src_gp_re = 1'($urandom);
      v.tgt_gp    = 4'($urandom_range(0, 3));
      v.tgt_gp_re = ($urandom % 4) == 0;
      v.tgt_gp_we = 1'($urandom);
      v.src_sr    = 2'($urandom);
      v.src_sr_re = ($urandom % 3) == 0;
      v.tgt_sr    = 2'($urandom);
      v.tgt_sr_we = ($urandom % 3) == 0;
      v.br        = ($urandom % 12) == 0;
      if (($urandom % 25) == 0) halt_lvl = ~halt_lvl;
      v.halt      = halt_lvl;
      v.resume    = ($urandom % 4) == 0;
      step(v, "random", 5'b0, 1'b0, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
